// File: rtl/riscv_run_ctrl.sv
// Run controller for a RISC-V core: holds the core in reset, runs it, and stops on
// a tohost write, an EBREAK retire or a cycle-budget timeout, latching the outcome.
module riscv_run_ctrl #(
    parameter int unsigned          RST_CYCLES  = 4,
    parameter int unsigned          MAX_CYCLES  = 100,
    parameter int                   CNT_W       = 32,
    parameter int                   XLEN        = 32,
    parameter logic [XLEN-1:0]      TOHOST_ADDR = 32'h0000_0FFC
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_dmem_wr_en,
    input  logic [XLEN-1:0]     i_dmem_addr,
    input  logic [XLEN-1:0]     i_dmem_wdata,
    input  logic                i_retire,
    input  logic [XLEN-1:0]     i_retire_instr,
    output logic                o_core_rstn,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_pass,
    output logic                o_timeout,
    output logic [XLEN-1:0]     o_exit_code,
    output logic [CNT_W-1:0]    o_cycle_cnt,
    output logic [CNT_W-1:0]    o_instret_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RESET = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [XLEN-1:0]  EBREAK_INSTR = XLEN'(32'h0010_0073);
    localparam logic [RST_W-1:0] RST_LAST     = RST_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CYCLE_LAST   = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [RST_W-1:0]   r_rst_cnt;
    logic               r_core_rstn;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic               r_timeout;
    logic [XLEN-1:0]    r_exit_code;
    logic [CNT_W-1:0]   r_cycle_cnt;
    logic [CNT_W-1:0]   r_instret_cnt;

    logic               w_in_run;
    logic               w_hit_tohost;
    logic               w_hit_ebreak;
    logic               w_hit_timeout;
    logic               w_stop;
    logic               w_rst_last;

    // Event decode is qualified by RUN so snoop traffic during core reset is ignored.
    always_comb begin
        w_in_run      = (r_state == S_RUN);
        w_hit_tohost  = w_in_run && i_dmem_wr_en && (i_dmem_addr == TOHOST_ADDR);
        w_hit_ebreak  = w_in_run && i_retire && (i_retire_instr == EBREAK_INSTR);
        w_hit_timeout = w_in_run && (r_cycle_cnt == CYCLE_LAST);
        w_stop        = w_hit_tohost || w_hit_ebreak || w_hit_timeout;
        w_rst_last    = (r_state == S_RESET) && (r_rst_cnt == RST_LAST);
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (i_start)   w_next_state = S_RESET;
            S_RESET: if (w_rst_last) w_next_state = S_RUN;
            S_RUN:   if (w_stop)    w_next_state = S_DONE;
            S_DONE:  if (i_start)   w_next_state = S_RESET;
            default:                w_next_state = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_rst_cnt     <= '0;
            r_core_rstn   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_timeout     <= 1'b0;
            r_exit_code   <= '0;
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            r_core_rstn <= (w_next_state == S_RUN);
            r_busy      <= (w_next_state == S_RESET) || (w_next_state == S_RUN);
            r_done      <= (w_next_state == S_DONE);

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_rst_cnt     <= '0;
                        r_pass        <= 1'b0;
                        r_timeout     <= 1'b0;
                        r_exit_code   <= '0;
                        r_cycle_cnt   <= '0;
                        r_instret_cnt <= '0;
                    end
                end
                S_RESET: begin
                    r_rst_cnt <= r_rst_cnt + RST_W'(1);
                end
                S_RUN: begin
                    r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
                    if (i_retire) begin
                        r_instret_cnt <= r_instret_cnt + CNT_ONE;
                    end
                    // Priority tohost > ebreak > timeout; only the winner is latched.
                    if (w_hit_tohost) begin
                        r_pass      <= (i_dmem_wdata == XLEN'(1));
                        r_exit_code <= i_dmem_wdata >> 1;
                        r_timeout   <= 1'b0;
                    end else if (w_hit_ebreak) begin
                        r_pass      <= 1'b0;
                        r_exit_code <= '1;
                        r_timeout   <= 1'b0;
                    end else if (w_hit_timeout) begin
                        r_pass      <= 1'b0;
                        r_exit_code <= '0;
                        r_timeout   <= 1'b1;
                    end
                end
                default: begin
                    r_rst_cnt <= '0;
                end
            endcase
        end
    end

    assign o_core_rstn   = r_core_rstn;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_pass        = r_pass;
    assign o_timeout     = r_timeout;
    assign o_exit_code   = r_exit_code;
    assign o_cycle_cnt   = r_cycle_cnt;
    assign o_instret_cnt = r_instret_cnt;

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Self-checking bench for riscv_run_ctrl: a small run model pushes expected outcomes
// into a scoreboard that is popped and compared when the controller reports done.
module tb_riscv_run_ctrl;

    localparam int unsigned RST_CYCLES  = 4;
    localparam int unsigned MAX_CYCLES  = 100;
    localparam int          CNT_W       = 32;
    localparam int          XLEN        = 32;
    localparam logic [31:0] TOHOST_ADDR = 32'h0000_0FFC;
    localparam logic [31:0] EBREAK      = 32'h0010_0073;
    localparam logic [31:0] NOP         = 32'h0000_0013;

    logic              i_clk;
    logic              i_rst;
    logic              i_start;
    logic              i_dmem_wr_en;
    logic [XLEN-1:0]   i_dmem_addr;
    logic [XLEN-1:0]   i_dmem_wdata;
    logic              i_retire;
    logic [XLEN-1:0]   i_retire_instr;
    logic              o_core_rstn;
    logic              o_busy;
    logic              o_done;
    logic              o_pass;
    logic              o_timeout;
    logic [XLEN-1:0]   o_exit_code;
    logic [CNT_W-1:0]  o_cycle_cnt;
    logic [CNT_W-1:0]  o_instret_cnt;

    typedef struct {
        logic        pass;
        logic        timeout;
        logic [31:0] exitCode;
        logic [31:0] cycles;
        logic [31:0] instret;
    } result_t;

    result_t     sbQueue[$];
    int          checkCount = 0;
    int          passCount  = 0;
    bit          modelRun   = 1'b0;
    int unsigned modelCycles  = 0;
    int unsigned modelInstret = 0;

    riscv_run_ctrl #(
        .RST_CYCLES (RST_CYCLES),
        .MAX_CYCLES (MAX_CYCLES),
        .CNT_W      (CNT_W),
        .XLEN       (XLEN),
        .TOHOST_ADDR(TOHOST_ADDR)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_dmem_wr_en  (i_dmem_wr_en),
        .i_dmem_addr   (i_dmem_addr),
        .i_dmem_wdata  (i_dmem_wdata),
        .i_retire      (i_retire),
        .i_retire_instr(i_retire_instr),
        .o_core_rstn   (o_core_rstn),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_pass        (o_pass),
        .o_timeout     (o_timeout),
        .o_exit_code   (o_exit_code),
        .o_cycle_cnt   (o_cycle_cnt),
        .o_instret_cnt (o_instret_cnt)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual=hung required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clearInputs();
        i_start        = 1'b0;
        i_dmem_wr_en   = 1'b0;
        i_dmem_addr    = '0;
        i_dmem_wdata   = '0;
        i_retire       = 1'b0;
        i_retire_instr = '0;
    endtask

    // Drives one cycle; while the model believes the core is running it predicts
    // the terminating event and queues the outcome the controller must report.
    task automatic applyStimulus(input logic start, input logic wrEn, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic retire,
                                 input logic [31:0] instr);
        result_t exp;
        bit t1, t2, t3;
        i_start        = start;
        i_dmem_wr_en   = wrEn;
        i_dmem_addr    = addr;
        i_dmem_wdata   = wdata;
        i_retire       = retire;
        i_retire_instr = instr;
        if (modelRun) begin
            t1 = wrEn && (addr == TOHOST_ADDR);
            t2 = retire && (instr == EBREAK);
            t3 = (modelCycles == MAX_CYCLES - 1);
            modelCycles++;
            if (retire) modelInstret++;
            if (t1 || t2 || t3) begin
                exp.cycles  = modelCycles;
                exp.instret = modelInstret;
                if (t1) begin
                    exp.pass     = (wdata == 32'd1);
                    exp.exitCode = wdata >> 1;
                    exp.timeout  = 1'b0;
                end else if (t2) begin
                    exp.pass     = 1'b0;
                    exp.exitCode = 32'hFFFF_FFFF;
                    exp.timeout  = 1'b0;
                end else begin
                    exp.pass     = 1'b0;
                    exp.exitCode = 32'd0;
                    exp.timeout  = 1'b1;
                end
                sbQueue.push_back(exp);
                modelRun = 1'b0;
            end
        end
        tick();
        clearInputs();
    endtask

    // Pulses start, holds garbage on the snoop ports during core reset and checks
    // the reset window length, ending on the first RUN cycle.
    task automatic startRun();
        i_start = 1'b1;
        tick();
        i_start        = 1'b0;
        i_dmem_wr_en   = 1'b1;
        i_dmem_addr    = TOHOST_ADDR;
        i_dmem_wdata   = 32'd1;
        i_retire       = 1'b1;
        i_retire_instr = EBREAK;
        checkOutput("startBusy",    64'(o_busy), 64'd1);
        checkOutput("startRstn",    64'(o_core_rstn), 64'd0);
        checkOutput("startDone",    64'(o_done), 64'd0);
        checkOutput("startCycles",  64'(o_cycle_cnt), 64'd0);
        checkOutput("startInstret", 64'(o_instret_cnt), 64'd0);
        checkOutput("startExit",    64'(o_exit_code), 64'd0);
        for (int k = 1; k < int'(RST_CYCLES); k++) begin
            tick();
            checkOutput("rstHoldRstn", 64'(o_core_rstn), 64'd0);
            checkOutput("rstHoldBusy", 64'(o_busy), 64'd1);
        end
        tick();
        clearInputs();
        checkOutput("runRstn",    64'(o_core_rstn), 64'd1);
        checkOutput("runBusy",    64'(o_busy), 64'd1);
        checkOutput("runCycles",  64'(o_cycle_cnt), 64'd0);
        checkOutput("runInstret", 64'(o_instret_cnt), 64'd0);
        modelRun     = 1'b1;
        modelCycles  = 0;
        modelInstret = 0;
    endtask

    task automatic collectResult();
        result_t exp;
        for (int i = 0; i < 200 && !o_done; i++) tick();
        checkOutput("doneSeen", 64'(o_done), 64'd1);
        checkOutput("sbDepth", 64'(sbQueue.size()), 64'd1);
        if (sbQueue.size() != 0) begin
            exp = sbQueue.pop_front();
            checkOutput("pass",    64'(o_pass), 64'(exp.pass));
            checkOutput("timeout", 64'(o_timeout), 64'(exp.timeout));
            checkOutput("exit",    64'(o_exit_code), 64'(exp.exitCode));
            checkOutput("cycles",  64'(o_cycle_cnt), 64'(exp.cycles));
            checkOutput("instret", 64'(o_instret_cnt), 64'(exp.instret));
            checkOutput("doneRstn", 64'(o_core_rstn), 64'd0);
            checkOutput("doneBusy", 64'(o_busy), 64'd0);
            tick();
            checkOutput("holdDone",   64'(o_done), 64'd1);
            checkOutput("holdCycles", 64'(o_cycle_cnt), 64'(exp.cycles));
            checkOutput("holdExit",   64'(o_exit_code), 64'(exp.exitCode));
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Rstn"},    64'(o_core_rstn), 64'd0);
        checkOutput({tag, "Busy"},    64'(o_busy), 64'd0);
        checkOutput({tag, "Done"},    64'(o_done), 64'd0);
        checkOutput({tag, "Pass"},    64'(o_pass), 64'd0);
        checkOutput({tag, "Timeout"}, 64'(o_timeout), 64'd0);
        checkOutput({tag, "Exit"},    64'(o_exit_code), 64'd0);
        checkOutput({tag, "Cycles"},  64'(o_cycle_cnt), 64'd0);
        checkOutput({tag, "Instret"}, 64'(o_instret_cnt), 64'd0);
    endtask

    initial begin
        clearInputs();
        i_rst = 1'b1;
        tick();
        tick();
        checkAllZero("reset");
        i_rst = 1'b0;
        tick();
        checkAllZero("idle");

        $display("[TB] pass run: tohost=1 on RUN cycle 10");
        startRun();
        for (int c = 1; c < 10; c++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, NOP);
        applyStimulus(1'b0, 1'b1, TOHOST_ADDR, 32'd1, 1'b1, NOP);
        collectResult();

        $display("[TB] fail code run with address miss");
        startRun();
        for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, '0, '0, c[0], NOP);
        applyStimulus(1'b0, 1'b1, 32'h0000_0FF8, 32'd7, 1'b1, NOP);
        checkOutput("addrMissNoStop", 64'(o_done), 64'd0);
        applyStimulus(1'b0, 1'b1, TOHOST_ADDR, 32'd7, 1'b0, NOP);
        collectResult();

        $display("[TB] timeout run");
        startRun();
        for (int c = 0; c < int'(MAX_CYCLES) - 1; c++)
            applyStimulus(1'b0, 1'b0, '0, '0, c[1], NOP);
        checkOutput("preTimeoutDone", 64'(o_done), 64'd0);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, NOP);
        collectResult();

        $display("[TB] collision run: tohost and ebreak together");
        startRun();
        for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, NOP);
        applyStimulus(1'b0, 1'b1, TOHOST_ADDR, 32'd5, 1'b1, EBREAK);
        collectResult();

        $display("[TB] ebreak run with ignored start");
        startRun();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, NOP);
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, NOP);
        applyStimulus(1'b0, 1'b1, 32'h0000_0100, 32'd1, 1'b0, NOP);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, EBREAK);
        collectResult();

        $display("[TB] mid-run reset");
        startRun();
        for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, NOP);
        i_rst = 1'b1;
        i_retire = 1'b1;
        i_retire_instr = NOP;
        tick();
        clearInputs();
        i_rst = 1'b0;
        modelRun = 1'b0;
        checkAllZero("midReset");

        $display("[TB] recovery run after reset");
        startRun();
        for (int c = 0; c < 2; c++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, NOP);
        applyStimulus(1'b0, 1'b1, TOHOST_ADDR, 32'd1, 1'b0, NOP);
        collectResult();
        checkOutput("sbDrained", 64'(sbQueue.size()), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
